// File: rtl/pc_call_stack.sv
// pc_call_stack: LIFO return-address stack for call/return instructions.
// The pop result is registered. Full, empty and count are decoded from the
// stack pointer. Overflow and underflow are sticky error flags.
//
// Strobe semantics: pushenbl and popenbl are sampled at every rising clk
// edge. Each cycle in which a strobe is high performs one operation. There
// is no ready/back-pressure. A pop (or a push+pop bypass) always answers one
// cycle later with a single-cycle pop_valid pulse, and pop_data is valid
// only in that cycle. When the pop hits an empty stack, pop_data is 0.
module pc_call_stack #(
  parameter  int PC_W  = 8,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushenbl,
  input  logic             popenbl,
  input  logic [PC_W-1:0]  push_data,
  input  logic             clr_err,
  output logic [PC_W-1:0]  pop_data,
  output logic             pop_valid,
  output logic             stack_empty,
  output logic             stack_full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PC_W-1:0]  mem_d [DEPTH];
  logic [CNT_W-1:0] sp_q, sp_d;
  logic [PC_W-1:0]  pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             is_empty, is_full;
  logic [CNT_W-1:0] sp_m1;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CNT_FULL);
  assign sp_m1    = sp_q - CNT_ONE;
  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = sp_m1[AW-1:0];

  // Next-state: push/pop/bypass decode, stack pointer, pop result, error flags.
  always_comb begin
    mem_d       = mem_q;
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    // Sticky flags clear on clr_err unless a new event sets them below.
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    unique case ({pushenbl, popenbl})
      2'b10: begin
        if (!is_full) begin
          mem_d[wr_idx] = push_data;
          sp_d          = sp_q + CNT_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        pop_valid_d = 1'b1;
        if (!is_empty) begin
          pop_data_d = mem_q[rd_idx];
          sp_d       = sp_m1;
        end else begin
          pop_data_d  = '0;
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        // Bypass: the pushed address is returned directly and the stack
        // is untouched, so neither boundary can produce an error.
        pop_valid_d = 1'b1;
        pop_data_d  = push_data;
      end
      default: ;
    endcase
  end

  // Control registers with synchronous reset; reset overrides all strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is not reset; writes are suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  assign pop_data    = pop_data_q;
  assign pop_valid   = pop_valid_q;
  assign count       = sp_q;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Testbench for pc_call_stack: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based LIFO reference model.
module tb_pc_call_stack;

  localparam int PC_W  = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             pushenbl;
  logic             popenbl;
  logic [PC_W-1:0]  push_data;
  logic             clr_err;
  logic [PC_W-1:0]  pop_data;
  logic             pop_valid;
  logic             stack_empty;
  logic             stack_full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  pc_call_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pushenbl   (pushenbl),
    .popenbl    (popenbl),
    .push_data  (push_data),
    .clr_err    (clr_err),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [PC_W-1:0] model_q[$];   // the LIFO contents, top at the back
  logic [PC_W-1:0] exp_q[$];     // expected pop results, in order
  logic [PC_W-1:0] m_data;
  logic            m_valid, m_ov, m_un;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_step(input logic rst, input logic push, input logic pop,
                            input logic [PC_W-1:0] d, input logic clr);
    logic ov_evt, un_evt;
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      m_data = '0; m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      return;
    end
    ov_evt  = push && !pop && (model_q.size() == DEPTH);
    un_evt  = pop && !push && (model_q.size() == 0);
    m_valid = pop;
    if (push && pop) begin
      m_data = d;
    end else if (push) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
    end else if (pop) begin
      m_data = (model_q.size() > 0) ? model_q.pop_back() : '0;
    end
    if (pop) exp_q.push_back(m_data);
    m_ov = ov_evt | (m_ov & ~clr);
    m_un = un_evt | (m_un & ~clr);
  endtask

  // Compare all outputs against the model after an edge.
  task automatic compare_all();
    check("pop_valid", 32'(pop_valid), 32'(m_valid));
    check("pop_data", 32'(pop_data), 32'(m_data));
    if (pop_valid && exp_q.size() > 0)
      check("pop_order", 32'(pop_data), 32'(exp_q.pop_front()));
    check("count", 32'(count), 32'(model_q.size()));
    check("stack_empty", 32'(stack_empty), 32'(model_q.size() == 0));
    check("stack_full", 32'(stack_full), 32'(model_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
  endtask

  // Driver: apply one cycle of inputs, clock it, then check.
  task automatic drive(input logic rst, input logic push, input logic pop,
                       input logic [PC_W-1:0] d, input logic clr);
    reset = rst; pushenbl = push; popenbl = pop; push_data = d; clr_err = clr;
    @(posedge clk);
    #1;
    model_step(rst, push, pop, d, clr);
    compare_all();
  endtask

  task automatic idle();      drive(1'b0, 1'b0, 1'b0, '0, 1'b0); endtask
  task automatic do_reset();  drive(1'b1, 1'b0, 1'b0, '0, 1'b0); endtask
  task automatic push(input logic [PC_W-1:0] d); drive(1'b0, 1'b1, 1'b0, d, 1'b0); endtask
  task automatic pop();       drive(1'b0, 1'b0, 1'b1, '0, 1'b0); endtask
  task automatic both(input logic [PC_W-1:0] d); drive(1'b0, 1'b1, 1'b1, d, 1'b0); endtask

  initial begin
    reset = 1'b1; pushenbl = 1'b0; popenbl = 1'b0; push_data = '0; clr_err = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    do_reset();

    // LIFO order: push 0x10,0x20,0x30 then pop three times
    push(8'h10); push(8'h20); push(8'h30);
    pop();  check("lifo_first", 32'(pop_data), 32'h30);
    pop();  check("lifo_second", 32'(pop_data), 32'h20);
    pop();  check("lifo_third", 32'(pop_data), 32'h10);
    check("lifo_empty", 32'(stack_empty), 32'd1);
    idle();

    // Fill, overflow, pop returns last stored value
    for (int i = 1; i <= DEPTH; i++) push(PC_W'(i));
    push(8'hFF);
    check("ovf_full", 32'(stack_full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    both(8'hA5);   // bypass while full: no new error, count unchanged
    check("bypass_full", 32'(pop_data), 32'hA5);
    pop();
    check("ovf_top", 32'(pop_data), 32'h08);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);   // clr_err
    check("ovf_cleared", 32'(overflow), 32'd0);
    while (model_q.size() > 0) pop();

    // Underflow from empty, then clear
    pop();
    check("unf_data", 32'(pop_data), 32'h00);
    check("unf_flag", 32'(underflow), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("unf_cleared", 32'(underflow), 32'd0);
    // Set wins over clear in the same cycle
    drive(1'b0, 1'b0, 1'b1, '0, 1'b1);
    check("unf_set_wins", 32'(underflow), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Bypass while empty
    both(8'h3C);
    check("bypass_empty", 32'(pop_data), 32'h3C);

    // Bypass with count=2
    push(8'h11); push(8'h22);
    both(8'h55);
    check("bypass_data", 32'(pop_data), 32'h55);
    check("bypass_count", 32'(count), 32'd2);
    pop();
    check("bypass_after", 32'(pop_data), 32'h22);
    pop();

    // Reset in the same cycle as a pop
    push(8'h11); push(8'h12);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    idle();

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      logic r_push, r_pop, r_clr, r_rst;
      bias   = ((i / 60) % 2 == 0) ? 70 : 30;
      r_push = ($urandom_range(0, 99) < bias);
      r_pop  = ($urandom_range(0, 99) < (100 - bias));
      r_clr  = ($urandom_range(0, 99) < 5);
      r_rst  = ($urandom_range(0, 299) == 0);
      drive(r_rst, r_push, r_pop, PC_W'($urandom), r_clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Return-address stack that responds to the `pushenbl`/`popenbl` strobes issued by the CPU control unit during EXECUTE for conditional-call and return instructions.
- Stores program-counter return addresses in LIFO order.
- Presents the popped address, registered, to the PC-update logic.
- Reports full/empty status and sticky overflow/underflow errors for the psw dump.

Parameters:
- PC_W, 8, width of a stored program-counter value.
- DEPTH, 8, number of stack entries; must be ≥ 2.
- CNT_W, $clog2(DEPTH+1) (4 at default), width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  CPU clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pushenbl  input  1  single-cycle push strobe from control.
- popenbl  input  1  single-cycle pop strobe from control.
- push_data  input  PC_W  return address to store; sampled when pushenbl=1.
- clr_err  input  1  synchronous clear of the sticky error flags.
- pop_data  output  PC_W  registered popped address.
- pop_valid  output  1  one-cycle pulse; pop_data is valid in this cycle.
- stack_empty  output  1  count == 0.
- stack_full  output  1  count == DEPTH.
- count  output  CNT_W  current occupancy.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high; it is sampled only at the rising clk edge.
- Reset values:
  - sp/count = 0, pop_data = 0, pop_valid = 0, overflow = 0, underflow = 0.
  - stack_empty = 1, stack_full = 0.
  - Storage array contents are not reset (don't care).
- Reset mid-operation: reset wins over every strobe in the same cycle. Any pending pop result is discarded, so pop_valid = 0 in the following cycle.
- Internal state:
  - Storage array mem[0..DEPTH-1] and stack pointer sp (== count).
  - sp points to the next free slot; the top of stack is mem[sp-1].
  - The state space is the count value 0..DEPTH; the only boundary states are EMPTY (0) and FULL (DEPTH).
- Push only (pushenbl=1, popenbl=0):
  - Not full: mem[sp] <= push_data; sp <= sp+1.
  - Full: no write; sp unchanged; overflow <= 1.
- Pop only (popenbl=1, pushenbl=0):
  - Not empty: pop_data <= mem[sp-1]; sp <= sp-1; pop_valid = 1 in the next cycle.
  - Empty: pop_data <= 0; sp unchanged; pop_valid = 1 in the next cycle; underflow <= 1.
- Push and pop together (pushenbl=1, popenbl=1):
  - Bypass: pop_data <= push_data; pop_valid = 1 next cycle.
  - sp and mem unchanged.
  - No overflow or underflow, regardless of whether the stack is full or empty.
- Neither strobe asserted: pop_valid = 0 next cycle; pop_data holds its last value.
- Latency:
  - Pop result is visible exactly 1 cycle after the popenbl edge.
  - stack_empty, stack_full and count reflect the updated sp in the same cycle as pop_valid.
- Status outputs: stack_empty, stack_full and count are decoded combinationally from the registered sp.
- Sticky error flags:
  - overflow and underflow hold until reset or clr_err=1.
  - If clr_err and a new error event occur in the same cycle, the flag is set (set wins).
- Wrap-around: none. sp never exceeds DEPTH and never goes below 0; there is no circular addressing.
- Strobes are level-sampled each cycle. Asserting a strobe for N consecutive cycles performs N operations.

Test Plan:
- Reset, then push 0x10, 0x20, 0x30 on consecutive cycles, then pop three times → pop_data = 0x30, 0x20, 0x10 on successive pop_valid pulses; count 3→0; stack_empty = 1 at the end.
- Push DEPTH=8 values 0x01..0x08, then push 0xFF → stack_full = 1, count = 8, overflow = 1. The next pop returns 0x08, not 0xFF.
- From empty, assert popenbl → pop_valid = 1 with pop_data = 0x00, underflow = 1, count = 0. Pulse clr_err → underflow = 0.
- With count = 2 (top 0x22), assert pushenbl and popenbl together with push_data = 0x55 → pop_data = 0x55, count stays 2. A following pop returns 0x22.
- Both strobes asserted while empty, and again while full → bypass value returned; count unchanged; overflow = underflow = 0.
- Push 0x11, 0x12, assert reset in the same cycle as a popenbl → the next cycle has pop_valid = 0, count = 0, stack_empty = 1, flags 0.
